adau_frame_packer: RTL and testbench
====================================

Name: adau_frame_packer

Overview:
- Downstream consumer of the analog acquisition unit's sample stream (sample_rdy / ADC_sample, 64-channel scan restarted on each sec pulse).
- Packs one sec-aligned scan into a ping-pong RAM of FRAME_LEN 16-bit words.
- Hands completed frames to a reader (telemetry/UART framer) via a frame_rdy / frame_ack handshake.
- Counts dropped and short frames so the reader can flag data loss.

Parameters:
- FRAME_LEN, 64, samples per frame (channels per scan)
- AW, 6, address width; 2**AW >= FRAME_LEN
- DW, 16, sample width

Ports:
- clk_5Mhz  in  1  block clock
- reset  in  1  asynchronous, active-high
- sec  in  1  one-cycle frame sync pulse; restarts channel index
- sample_rdy  in  1  sample strobe from ADC path; may stay high more than one cycle, only its rising edge counts
- ADC_sample  in  DW  sample value; valid on the sample_rdy rising edge
- frame_rdy  out  1  completed frame available in bank rd_bank
- rd_bank  out  1  bank currently owned by the reader
- frame_ack  in  1  one-cycle pulse; reader releases its bank
- rd_addr  in  AW  reader word address
- rd_data  out  DW  word at rd_addr of bank rd_bank, registered
- wr_index  out  AW  next write position in the current frame
- frame_cnt  out  16  completed frames delivered, wraps
- drop_cnt  out  8  completed frames dropped by overrun, saturates at 255
- short_cnt  out  8  partial frames discarded by sec, saturates at 255
- overrun  out  1  sticky drop flag

Behaviour:
- Reset values: frame_rdy=0, rd_bank=1, wr_bank=0, wr_index=0, frame_cnt=0, drop_cnt=0, short_cnt=0, overrun=0, rd_data=0, sample_rdy_d=0, state=WAIT_SYNC.
- Reset asserted mid-frame drops all state; the partial frame is not counted.
- Edge detect: edge = sample_rdy & ~sample_rdy_d, where sample_rdy_d is a registered copy.
- States:
  - WAIT_SYNC: edges are ignored. On sec -> COLLECT with wr_index=0.
  - COLLECT: on edge, write ADC_sample to RAM[wr_bank][wr_index] on that clock edge, then wr_index+1.
  - COLLECT, sec with wr_index!=0: discard the partial frame, wr_index=0, short_cnt+1. Stay in COLLECT.
  - COLLECT, sec with wr_index==0: no counter changes.
- sec and edge in the same cycle: sec wins for the index. The sample is written at index 0 of the new frame and wr_index=1. In WAIT_SYNC this also applies: enter COLLECT with wr_index=1.
- Frame completion (edge while wr_index==FRAME_LEN-1), acting in the same clock edge as the final write:
  - Reader free (frame_rdy=0, or frame_ack=1 this cycle): rd_bank<=wr_bank, wr_bank toggles, frame_rdy<=1, frame_cnt+1, wr_index<=0.
  - Reader busy (frame_rdy=1 and no ack): frame dropped, banks unchanged (next frame overwrites wr_bank), drop_cnt+1, overrun<=1, wr_index<=0.
  - State stays COLLECT; wr_index wraps to 0 with no further sec needed.
- frame_ack:
  - Clears frame_rdy next cycle.
  - Ack while frame_rdy=0 is ignored.
  - Ack coinciding with a completion: the new frame is delivered and frame_rdy stays 1.
- Read port: rd_data <= RAM[rd_bank][rd_addr], 1-cycle latency, independent of frame_rdy.
  - Reads are combinationally unaffected by writes (separate banks).
  - rd_addr >= FRAME_LEN returns undefined data.
- overrun clears only on reset.
- frame_cnt wraps 0xFFFF->0. drop_cnt and short_cnt saturate at 0xFF.
- RAM: 2*FRAME_LEN x DW, one write port and one read port, inferred; address = {bank, index}.

Test Plan:
- Reset, sec, 64 edges with ADC_sample=0x1000+n -> frame_rdy=1 the cycle after the 64th write, rd_bank=0, frame_cnt=1. Reading addr 0..63 returns 0x1000..0x103F, one cycle after each address.
- sample_rdy held high 5 cycles per sample, 64 samples -> exactly 64 writes, wr_index steps once per pulse, single frame delivered.
- Edges before the first sec (10 samples), then sec plus 64 samples -> pre-sync samples ignored, frame holds only post-sec data, short_cnt=0.
- sec after 20 samples, then 64 samples 0x2000+n -> short_cnt=1. Delivered frame holds 0x2000..0x203F; none of the first 20 remain at indices 0..19.
- Frame 1 delivered with no ack, frame 2 completes -> drop_cnt=1, overrun=1, frame_cnt=1, rd_bank unchanged, frame 1 data intact. Then ack plus frame 3 -> frame_cnt=2, rd_bank=1, data equals frame 3.
- frame_ack in the same cycle as the final write of frame 2 -> no drop, frame_rdy stays 1, rd_bank toggles to 1, frame_cnt=2. Reset asserted mid-frame -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/adau_frame_packer.sv
// adau_frame_packer
//   Packs one sec-aligned 64-channel ADC scan into a ping-pong RAM and hands
//   completed frames to a reader through a frame_rdy / frame_ack handshake.
//   Dropped frames (reader still busy) and short frames (sec arriving
//   mid-scan) are counted so the reader can flag data loss.
//
// Ports
//   clk_5Mhz    in   block clock
//   reset       in   asynchronous, active-high
//   sec         in   one-cycle frame sync; restarts the channel index
//   sample_rdy  in   sample strobe; only its rising edge counts
//   ADC_sample  in   sample value, valid on the sample_rdy rising edge
//   frame_rdy   out  completed frame available in bank rd_bank
//   rd_bank     out  bank owned by the reader
//   frame_ack   in   one-cycle pulse; reader releases its bank
//   rd_addr     in   reader word address
//   rd_data     out  RAM[rd_bank][rd_addr], one cycle latency
//   wr_index    out  next write position in the current frame
//   frame_cnt   out  delivered frames, wraps
//   drop_cnt    out  frames dropped by overrun, saturates
//   short_cnt   out  partial frames discarded by sec, saturates
//   overrun     out  sticky drop flag, cleared only by reset
module adau_frame_packer #(
   parameter int FRAME_LEN = 64,
   parameter int AW        = 6,
   parameter int DW        = 16
) (
   input  logic          clk_5Mhz,
   input  logic          reset,
   input  logic          sec,
   input  logic          sample_rdy,
   input  logic [DW-1:0] ADC_sample,
   output logic          frame_rdy,
   output logic          rd_bank,
   input  logic          frame_ack,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic [AW-1:0] wr_index,
   output logic [15:0]   frame_cnt,
   output logic [7:0]    drop_cnt,
   output logic [7:0]    short_cnt,
   output logic          overrun
);

   localparam int           DEPTH = 2 ** (AW + 1);
   localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

   typedef enum logic {WAIT_SYNC, COLLECT} state_t;

   state_t        state_q, state_d;
   logic          sample_rdy_q;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic          frame_rdy_q, frame_rdy_d;
   logic [AW-1:0] wr_index_q, wr_index_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;
   logic [7:0]    short_cnt_q, short_cnt_d;
   logic          overrun_q, overrun_d;
   logic [DW-1:0] rd_data_q;

   logic          smp_edge;
   logic          we;
   logic          complete;
   logic          reader_free;
   logic [AW-1:0] wr_addr;

   logic [DW-1:0] mem [0:DEPTH-1];

   always_comb begin
      smp_edge    = sample_rdy & ~sample_rdy_q;
      // sec restarts the frame, so a coincident sample lands at index 0
      wr_addr     = sec ? '0 : wr_index_q;
      we          = smp_edge & (sec | (state_q == COLLECT));
      complete    = we & ~sec & (wr_index_q == LAST);
      // an ack in the completion cycle frees the reader bank for handover
      reader_free = ~frame_rdy_q | frame_ack;

      state_d     = state_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      frame_rdy_d = frame_rdy_q;
      wr_index_d  = wr_index_q;
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      short_cnt_d = short_cnt_q;
      overrun_d   = overrun_q;

      if (sec) state_d = COLLECT;

      if (sec && (state_q == COLLECT) && (wr_index_q != '0) && (short_cnt_q != 8'hFF))
         short_cnt_d = short_cnt_q + 8'd1;

      if (frame_ack) frame_rdy_d = 1'b0;

      if (complete) begin
         wr_index_d = '0;
         if (reader_free) begin
            rd_bank_d   = wr_bank_q;
            wr_bank_d   = ~wr_bank_q;
            frame_rdy_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
         end else begin
            // reader still holds its bank: next frame overwrites wr_bank
            overrun_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end else if (we) begin
         wr_index_d = wr_addr + AW'(1);
      end else if (sec) begin
         wr_index_d = '0;
      end
   end

   always_ff @(posedge clk_5Mhz or posedge reset) begin
      if (reset) begin
         state_q      <= WAIT_SYNC;
         sample_rdy_q <= 1'b0;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b1;
         frame_rdy_q  <= 1'b0;
         wr_index_q   <= '0;
         frame_cnt_q  <= '0;
         drop_cnt_q   <= '0;
         short_cnt_q  <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sample_rdy_q <= sample_rdy;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         frame_rdy_q  <= frame_rdy_d;
         wr_index_q   <= wr_index_d;
         frame_cnt_q  <= frame_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         short_cnt_q  <= short_cnt_d;
         overrun_q    <= overrun_d;
      end
   end

   // Frame RAM, address = {bank, index}
   always_ff @(posedge clk_5Mhz) begin
      if (we) mem[{wr_bank_q, wr_addr}] <= ADC_sample;
   end

   always_ff @(posedge clk_5Mhz or posedge reset) begin
      if (reset) rd_data_q <= '0;
      else       rd_data_q <= mem[{rd_bank_q, rd_addr}];
   end

   assign frame_rdy = frame_rdy_q;
   assign rd_bank   = rd_bank_q;
   assign rd_data   = rd_data_q;
   assign wr_index  = wr_index_q;
   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
   assign short_cnt = short_cnt_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_adau_frame_packer.sv
module tb_adau_frame_packer;

   logic        clk_5Mhz = 1'b0;
   logic        reset = 1'b1;
   logic        sec = 1'b0;
   logic        sample_rdy = 1'b0;
   logic [15:0] ADC_sample = '0;
   logic        frame_rdy;
   logic        rd_bank;
   logic        frame_ack = 1'b0;
   logic [5:0]  rd_addr = '0;
   logic [15:0] rd_data;
   logic [5:0]  wr_index;
   logic [15:0] frame_cnt;
   logic [7:0]  drop_cnt;
   logic [7:0]  short_cnt;
   logic        overrun;

   int errors = 0;
   int checks = 0;

   adau_frame_packer #(.FRAME_LEN(64), .AW(6), .DW(16)) dut (
      .clk_5Mhz(clk_5Mhz), .reset(reset), .sec(sec), .sample_rdy(sample_rdy),
      .ADC_sample(ADC_sample), .frame_rdy(frame_rdy), .rd_bank(rd_bank),
      .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_index(wr_index), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
      .short_cnt(short_cnt), .overrun(overrun)
   );

   always #100 clk_5Mhz = ~clk_5Mhz;

   // advance one clock; outputs are stable 1 time unit after the edge
   task automatic tick();
      @(posedge clk_5Mhz);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; sec = 1'b0; sample_rdy = 1'b0; frame_ack = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic pulse_sec();
      sec = 1'b1; tick(); sec = 1'b0;
   endtask

   task automatic send_sample(input logic [15:0] v, input int hold);
      sample_rdy = 1'b1; ADC_sample = v;
      repeat (hold) tick();
      sample_rdy = 1'b0;
      tick();
   endtask

   task automatic sec_and_sample(input logic [15:0] v);
      sec = 1'b1; sample_rdy = 1'b1; ADC_sample = v;
      tick();
      sec = 1'b0; sample_rdy = 1'b0;
      tick();
   endtask

   task automatic send_frame(input logic [15:0] base);
      for (int n = 0; n < 64; n++) send_sample(base + 16'(n), 1);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (frame_rdy !== 1'b0) begin errors++; $display("FAIL reset_frame_rdy got=%0b exp=0", frame_rdy); end
      checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL reset_rd_bank got=%0b exp=1", rd_bank); end
      checks++; if (wr_index !== 6'd0) begin errors++; $display("FAIL reset_wr_index got=%0d exp=0", wr_index); end
      checks++; if (frame_cnt !== 16'd0 || drop_cnt !== 8'd0 || short_cnt !== 8'd0)
         begin errors++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", frame_cnt, drop_cnt, short_cnt); end
      checks++; if (overrun !== 1'b0 || rd_data !== 16'h0) begin errors++; $display("FAIL reset_ovr_data got=%0b/%h exp=0/0000", overrun, rd_data); end
      // ack with no frame pending is ignored
      frame_ack = 1'b1; tick(); frame_ack = 1'b0; tick();
      checks++; if (frame_rdy !== 1'b0 || rd_bank !== 1'b1) begin errors++; $display("FAIL idle_ack got=%0b/%0b exp=0/1", frame_rdy, rd_bank); end
   endtask

   task automatic test_basic_frame();
      do_reset();
      pulse_sec();
      for (int n = 0; n < 63; n++) send_sample(16'h1000 + 16'(n), 1);
      checks++; if (frame_rdy !== 1'b0 || wr_index !== 6'd63) begin errors++; $display("FAIL basic_pre_last got=%0b/%0d exp=0/63", frame_rdy, wr_index); end
      sample_rdy = 1'b1; ADC_sample = 16'h103F;
      tick();
      checks++; if (frame_rdy !== 1'b1) begin errors++; $display("FAIL basic_frame_rdy got=%0b exp=1", frame_rdy); end
      sample_rdy = 1'b0; tick();
      checks++; if (rd_bank !== 1'b0 || frame_cnt !== 16'd1 || wr_index !== 6'd0)
         begin errors++; $display("FAIL basic_state got=%0b/%0d/%0d exp=0/1/0", rd_bank, frame_cnt, wr_index); end
      for (int a = 0; a < 64; a++) begin
         rd_addr = 6'(a); tick();
         checks++; if (rd_data !== 16'h1000 + 16'(a)) begin errors++; $display("FAIL basic_data[%0d] got=%h exp=%h", a, rd_data, 16'h1000 + 16'(a)); end
      end
      frame_ack = 1'b1; tick(); frame_ack = 1'b0;
      checks++; if (frame_rdy !== 1'b0) begin errors++; $display("FAIL basic_ack_clear got=%0b exp=0", frame_rdy); end
   endtask

   task automatic test_held_strobe();
      do_reset();
      pulse_sec();
      for (int n = 0; n < 10; n++) send_sample(16'h3000 + 16'(n), 5);
      checks++; if (wr_index !== 6'd10) begin errors++; $display("FAIL held_index got=%0d exp=10", wr_index); end
      for (int n = 10; n < 64; n++) send_sample(16'h3000 + 16'(n), 5);
      checks++; if (frame_cnt !== 16'd1 || frame_rdy !== 1'b1 || wr_index !== 6'd0 || drop_cnt !== 8'd0)
         begin errors++; $display("FAIL held_frame got=%0d/%0b/%0d/%0d exp=1/1/0/0", frame_cnt, frame_rdy, wr_index, drop_cnt); end
      for (int a = 0; a < 64; a++) begin
         rd_addr = 6'(a); tick();
         checks++; if (rd_data !== 16'h3000 + 16'(a)) begin errors++; $display("FAIL held_data[%0d] got=%h exp=%h", a, rd_data, 16'h3000 + 16'(a)); end
      end
   endtask

   task automatic test_presync();
      do_reset();
      for (int n = 0; n < 10; n++) send_sample(16'h0AA0 + 16'(n), 1);
      checks++; if (wr_index !== 6'd0) begin errors++; $display("FAIL presync_index got=%0d exp=0", wr_index); end
      pulse_sec();
      send_frame(16'h4000);
      checks++; if (short_cnt !== 8'd0 || frame_cnt !== 16'd1) begin errors++; $display("FAIL presync_cnt got=%0d/%0d exp=0/1", short_cnt, frame_cnt); end
      for (int a = 0; a < 64; a++) begin
         rd_addr = 6'(a); tick();
         checks++; if (rd_data !== 16'h4000 + 16'(a)) begin errors++; $display("FAIL presync_data[%0d] got=%h exp=%h", a, rd_data, 16'h4000 + 16'(a)); end
      end
   endtask

   task automatic test_short_frame();
      do_reset();
      pulse_sec();
      for (int n = 0; n < 20; n++) send_sample(16'h5000 + 16'(n), 1);
      checks++; if (wr_index !== 6'd20) begin errors++; $display("FAIL short_index got=%0d exp=20", wr_index); end
      pulse_sec();
      checks++; if (short_cnt !== 8'd1 || wr_index !== 6'd0) begin errors++; $display("FAIL short_cnt got=%0d/%0d exp=1/0", short_cnt, wr_index); end
      // sec again at index 0 changes nothing
      pulse_sec();
      checks++; if (short_cnt !== 8'd1) begin errors++; $display("FAIL short_idle_sec got=%0d exp=1", short_cnt); end
      send_frame(16'h2000);
      checks++; if (frame_cnt !== 16'd1 || rd_bank !== 1'b0) begin errors++; $display("FAIL short_frame got=%0d/%0b exp=1/0", frame_cnt, rd_bank); end
      for (int a = 0; a < 64; a++) begin
         rd_addr = 6'(a); tick();
         checks++; if (rd_data !== 16'h2000 + 16'(a)) begin errors++; $display("FAIL short_data[%0d] got=%h exp=%h", a, rd_data, 16'h2000 + 16'(a)); end
      end
   endtask

   task automatic test_overrun();
      do_reset();
      pulse_sec();
      send_frame(16'h6000);
      send_frame(16'h7000);
      checks++; if (drop_cnt !== 8'd1 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%0d/%0b exp=1/1", drop_cnt, overrun); end
      checks++; if (frame_cnt !== 16'd1 || rd_bank !== 1'b0 || frame_rdy !== 1'b1)
         begin errors++; $display("FAIL ovr_state got=%0d/%0b/%0b exp=1/0/1", frame_cnt, rd_bank, frame_rdy); end
      for (int a = 0; a < 64; a++) begin
         rd_addr = 6'(a); tick();
         checks++; if (rd_data !== 16'h6000 + 16'(a)) begin errors++; $display("FAIL ovr_keep[%0d] got=%h exp=%h", a, rd_data, 16'h6000 + 16'(a)); end
      end
      frame_ack = 1'b1; tick(); frame_ack = 1'b0;
      checks++; if (frame_rdy !== 1'b0) begin errors++; $display("FAIL ovr_ack got=%0b exp=0", frame_rdy); end
      send_frame(16'h8000);
      checks++; if (frame_cnt !== 16'd2 || rd_bank !== 1'b1 || overrun !== 1'b1 || drop_cnt !== 8'd1)
         begin errors++; $display("FAIL ovr_frame3 got=%0d/%0b/%0b/%0d exp=2/1/1/1", frame_cnt, rd_bank, overrun, drop_cnt); end
      for (int a = 0; a < 64; a++) begin
         rd_addr = 6'(a); tick();
         checks++; if (rd_data !== 16'h8000 + 16'(a)) begin errors++; $display("FAIL ovr_f3[%0d] got=%h exp=%h", a, rd_data, 16'h8000 + 16'(a)); end
      end
   endtask

   task automatic test_ack_coincide();
      do_reset();
      pulse_sec();
      send_frame(16'h9000);
      for (int n = 0; n < 63; n++) send_sample(16'hA000 + 16'(n), 1);
      sample_rdy = 1'b1; ADC_sample = 16'hA03F; frame_ack = 1'b1;
      tick();
      sample_rdy = 1'b0; frame_ack = 1'b0;
      tick();
      checks++; if (frame_rdy !== 1'b1 || rd_bank !== 1'b1) begin errors++; $display("FAIL coinc_rdy got=%0b/%0b exp=1/1", frame_rdy, rd_bank); end
      checks++; if (frame_cnt !== 16'd2 || drop_cnt !== 8'd0 || overrun !== 1'b0)
         begin errors++; $display("FAIL coinc_cnt got=%0d/%0d/%0b exp=2/0/0", frame_cnt, drop_cnt, overrun); end
      for (int a = 0; a < 64; a++) begin
         rd_addr = 6'(a); tick();
         checks++; if (rd_data !== 16'hA000 + 16'(a)) begin errors++; $display("FAIL coinc_data[%0d] got=%h exp=%h", a, rd_data, 16'hA000 + 16'(a)); end
      end
   endtask

   task automatic test_sec_edge();
      do_reset();
      sec_and_sample(16'hB000);
      checks++; if (wr_index !== 6'd1 || short_cnt !== 8'd0) begin errors++; $display("FAIL secedge_sync got=%0d/%0d exp=1/0", wr_index, short_cnt); end
      for (int n = 1; n < 5; n++) send_sample(16'hB000 + 16'(n), 1);
      sec_and_sample(16'hC000);
      checks++; if (wr_index !== 6'd1 || short_cnt !== 8'd1) begin errors++; $display("FAIL secedge_mid got=%0d/%0d exp=1/1", wr_index, short_cnt); end
      for (int n = 1; n < 64; n++) send_sample(16'hC000 + 16'(n), 1);
      checks++; if (frame_cnt !== 16'd1 || frame_rdy !== 1'b1) begin errors++; $display("FAIL secedge_frame got=%0d/%0b exp=1/1", frame_cnt, frame_rdy); end
      for (int a = 0; a < 64; a++) begin
         rd_addr = 6'(a); tick();
         checks++; if (rd_data !== 16'hC000 + 16'(a)) begin errors++; $display("FAIL secedge_data[%0d] got=%h exp=%h", a, rd_data, 16'hC000 + 16'(a)); end
      end
   endtask

   task automatic test_short_saturate();
      do_reset();
      pulse_sec();
      for (int n = 0; n < 260; n++) begin
         send_sample(16'h0100, 1);
         pulse_sec();
      end
      checks++; if (short_cnt !== 8'hFF) begin errors++; $display("FAIL short_sat got=%0d exp=255", short_cnt); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      pulse_sec();
      send_frame(16'hD000);
      for (int n = 0; n < 10; n++) send_sample(16'hE000 + 16'(n), 1);
      pulse_sec();
      send_sample(16'hE100, 1);
      checks++; if (frame_rdy !== 1'b1 || short_cnt !== 8'd1 || wr_index !== 6'd1)
         begin errors++; $display("FAIL midrst_pre got=%0b/%0d/%0d exp=1/1/1", frame_rdy, short_cnt, wr_index); end
      reset = 1'b1;
      tick();
      checks++; if (frame_rdy !== 1'b0 || rd_bank !== 1'b1 || wr_index !== 6'd0)
         begin errors++; $display("FAIL midrst_ctl got=%0b/%0b/%0d exp=0/1/0", frame_rdy, rd_bank, wr_index); end
      checks++; if (frame_cnt !== 16'd0 || short_cnt !== 8'd0 || drop_cnt !== 8'd0 || overrun !== 1'b0 || rd_data !== 16'h0)
         begin errors++; $display("FAIL midrst_cnt got=%0d/%0d/%0d/%0b/%h exp=0/0/0/0/0000", frame_cnt, short_cnt, drop_cnt, overrun, rd_data); end
      reset = 1'b0;
      tick();
      // back in WAIT_SYNC: samples without sec are ignored
      send_sample(16'hF000, 1);
      checks++; if (wr_index !== 6'd0) begin errors++; $display("FAIL midrst_wait got=%0d exp=0", wr_index); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_held_strobe();
      test_presync();
      test_short_frame();
      test_overrun();
      test_ack_coincide();
      test_sec_edge();
      test_short_saturate();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
